// File: rtl/bubble_ctrl.sv
// Fetch-stage bubble controller: turns load/branch hazard requests into PC and
// IF/ID enables, NOP injection and branch redirect, with stall statistics.
module bubble_ctrl #(
  parameter int BRANCH_WAIT_MAX = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_bubble,
  input  logic                 branch_bubble,
  input  logic                 branch_resolved,
  input  logic                 branch_taken,
  input  logic [0:31]          branch_target,
  output logic                 pc_write_en,
  output logic                 ifid_write_en,
  output logic                 inject_nop,
  output logic                 pc_sel_target,
  output logic [0:31]          redirect_pc,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] load_stall_count,
  output logic [CNT_WIDTH-1:0] branch_stall_count
);

  localparam int WAIT_W = (BRANCH_WAIT_MAX > 1) ? $clog2(BRANCH_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BRANCH_WAIT_MAX - 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, BRANCH_WAIT, REDIRECT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Mealy control outputs so a stall lands in the same cycle the hazard is raised.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    inject_nop    = 1'b0;
    pc_sel_target = 1'b0;
    if (reset) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      inject_nop    = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_bubble || load_bubble) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            inject_nop    = 1'b1;
          end
        end
        LOAD_STALL: begin
          if (branch_bubble) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            inject_nop    = 1'b1;
          end
        end
        BRANCH_WAIT: begin
          if ((branch_resolved && branch_taken) ||
              (!branch_resolved && !wait_expired)) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            inject_nop    = 1'b1;
          end
        end
        REDIRECT: begin
          pc_sel_target = 1'b1;
          inject_nop    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= RUN;
      wait_cnt           <= '0;
      redirect_pc        <= '0;
      timeout_err        <= 1'b0;
      load_stall_count   <= '0;
      branch_stall_count <= '0;
    end else begin
      case (state)
        RUN, LOAD_STALL: begin
          if (branch_bubble) begin
            if (branch_stall_count != '1)
              branch_stall_count <= branch_stall_count + CNT_WIDTH'(1);
            wait_cnt <= '0;
            state    <= BRANCH_WAIT;
          end else if (load_bubble && state == RUN) begin
            if (load_stall_count != '1)
              load_stall_count <= load_stall_count + CNT_WIDTH'(1);
            state <= LOAD_STALL;
          end else begin
            state <= RUN;
          end
        end
        BRANCH_WAIT: begin
          // A resolve always beats the timeout, even on the last wait cycle.
          if (branch_resolved) begin
            if (branch_taken) begin
              redirect_pc <= branch_target;
              state       <= REDIRECT;
            end else begin
              state <= RUN;
            end
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            state       <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_ctrl.sv
// Self-checking bench for bubble_ctrl: directed test-plan steps followed by
// random traffic, compared against a behavioural model of the stall protocol.
module tb_bubble_ctrl;

  localparam int WAIT_MAX = 4;

  logic        clk;
  logic        reset;
  logic        load_bubble;
  logic        branch_bubble;
  logic        branch_resolved;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        pc_write_en, ifid_write_en, inject_nop, pc_sel_target, timeout_err;
  logic [0:31] redirect_pc;
  logic [15:0] load_stall_count, branch_stall_count;

  logic        s_pc_write_en, s_ifid_write_en, s_inject_nop, s_pc_sel_target, s_timeout_err;
  logic [0:31] s_redirect_pc;
  logic [1:0]  s_load_stall_count, s_branch_stall_count;

  int errors = 0;
  int checks = 0;

  // Model of the protocol: which phase the fetch stage is in, and history.
  bit          mRedirectNext;
  bit          mBranchWaiting;
  bit          mLoadGrace;
  int          mWaitCycles;
  int          mLoadStalls;
  int          mBranchStalls;
  logic [31:0] mRedirectPc;
  bit          mTimeout;

  bubble_ctrl #(.BRANCH_WAIT_MAX(WAIT_MAX), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load_bubble(load_bubble), .branch_bubble(branch_bubble),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write_en(pc_write_en),
    .ifid_write_en(ifid_write_en), .inject_nop(inject_nop),
    .pc_sel_target(pc_sel_target), .redirect_pc(redirect_pc),
    .timeout_err(timeout_err), .load_stall_count(load_stall_count),
    .branch_stall_count(branch_stall_count)
  );

  bubble_ctrl #(.BRANCH_WAIT_MAX(WAIT_MAX), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .load_bubble(load_bubble), .branch_bubble(branch_bubble),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write_en(s_pc_write_en),
    .ifid_write_en(s_ifid_write_en), .inject_nop(s_inject_nop),
    .pc_sel_target(s_pc_sel_target), .redirect_pc(s_redirect_pc),
    .timeout_err(s_timeout_err), .load_stall_count(s_load_stall_count),
    .branch_stall_count(s_branch_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satTo(input int value, input int maxVal);
    return (value > maxVal) ? maxVal : value;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, check the Mealy outputs, clock, check registered state.
  task automatic applyStimulus(input logic rst, input logic lb, input logic bb,
                               input logic res, input logic tk, input logic [31:0] tgt);
    bit expStall, expRelease;
    bit nRedirect, nWaiting, nGrace, nTimeout;
    int nWait, nLoads, nBranches;
    logic [31:0] nPc;
    reset = rst; load_bubble = lb; branch_bubble = bb;
    branch_resolved = res; branch_taken = tk; branch_target = tgt;
    #1;
    expStall = 1'b0;
    expRelease = 1'b0;
    if (rst) begin
      checkOutput("rst_pc_we", pc_write_en, 0);
      checkOutput("rst_ifid_we", ifid_write_en, 0);
      checkOutput("rst_nop", inject_nop, 1);
      checkOutput("rst_sel", pc_sel_target, 0);
    end else if (mRedirectNext) begin
      checkOutput("redir_pc_we", pc_write_en, 1);
      checkOutput("redir_ifid_we", ifid_write_en, 1);
      checkOutput("redir_nop", inject_nop, 1);
      checkOutput("redir_sel", pc_sel_target, 1);
    end else begin
      if (mBranchWaiting)
        expStall = res ? tk : (mWaitCycles < WAIT_MAX - 1);
      else
        expStall = bb || (lb && !mLoadGrace);
      checkOutput("pc_we", pc_write_en, {31'b0, !expStall});
      checkOutput("ifid_we", ifid_write_en, {31'b0, !expStall});
      checkOutput("nop", inject_nop, {31'b0, expStall});
      checkOutput("sel", pc_sel_target, 0);
    end
    checkOutput("small_pc_we", s_pc_write_en, pc_write_en);

    nRedirect = 1'b0; nWaiting = mBranchWaiting; nGrace = 1'b0;
    nWait = mWaitCycles; nLoads = mLoadStalls; nBranches = mBranchStalls;
    nPc = mRedirectPc; nTimeout = mTimeout;
    if (rst) begin
      nWaiting = 1'b0; nWait = 0; nLoads = 0; nBranches = 0; nPc = 0; nTimeout = 0;
    end else if (mRedirectNext) begin
      nWaiting = 1'b0;
    end else if (mBranchWaiting) begin
      if (res && tk) begin
        nRedirect = 1'b1; nWaiting = 1'b0; nPc = tgt;
      end else if (res) begin
        nWaiting = 1'b0;
      end else if (mWaitCycles == WAIT_MAX - 1) begin
        nWaiting = 1'b0; nTimeout = 1'b1;
      end else begin
        nWait = mWaitCycles + 1;
      end
    end else if (bb) begin
      nWaiting = 1'b1; nWait = 0; nBranches = mBranchStalls + 1;
    end else if (lb && !mLoadGrace) begin
      nGrace = 1'b1; nLoads = mLoadStalls + 1;
    end
    expRelease = expStall;

    @(posedge clk);
    #1;
    mRedirectNext = nRedirect; mBranchWaiting = nWaiting; mLoadGrace = nGrace;
    mWaitCycles = nWait; mLoadStalls = nLoads; mBranchStalls = nBranches;
    mRedirectPc = nPc; mTimeout = nTimeout;

    checkOutput("load_cnt", {16'b0, load_stall_count}, satTo(mLoadStalls, 65535));
    checkOutput("branch_cnt", {16'b0, branch_stall_count}, satTo(mBranchStalls, 65535));
    checkOutput("small_load_cnt", {30'b0, s_load_stall_count}, satTo(mLoadStalls, 3));
    checkOutput("small_branch_cnt", {30'b0, s_branch_stall_count}, satTo(mBranchStalls, 3));
    checkOutput("redirect_pc", redirect_pc, mRedirectPc);
    checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, mTimeout});
  endtask

  initial begin
    reset = 1'b1; load_bubble = 0; branch_bubble = 0;
    branch_resolved = 0; branch_taken = 0; branch_target = '0;
    mRedirectNext = 0; mBranchWaiting = 0; mLoadGrace = 0; mWaitCycles = 0;
    mLoadStalls = 0; mBranchStalls = 0; mRedirectPc = '0; mTimeout = 0;
    @(posedge clk);
    #1;

    // Reset for two cycles, then idle.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_pc_we", pc_write_en, 1);

    // Load request held three cycles: stall, grace, stall again.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("load_cnt_two", {16'b0, load_stall_count}, 2);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Branch resolved taken two cycles after the request.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_0100);
    checkOutput("redirect_target", redirect_pc, 32'h100);
    checkOutput("redirect_sel_now", pc_sel_target, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Branch resolved not-taken after one cycle.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // No resolve: forced release on the last wait cycle, sticky timeout.
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("timeout_set", {31'b0, timeout_err}, 1);
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_0040);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // After reset, resolve exactly on the timeout cycle: no timeout.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("timeout_clear", {31'b0, timeout_err}, 0);

    // Both requests together take the branch path.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("both_branch_cnt", {16'b0, branch_stall_count}, 1);
    checkOutput("both_load_cnt", {16'b0, load_stall_count}, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Reset in the middle of a branch wait abandons it.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 32'h0000_0200);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Random traffic, including saturation of the narrow counters.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1) == 1,
                    $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
